// File: rtl/dma_io_endpoint_if.sv
// DMA controller <-> peripheral handshake and data bus bundle.
interface dma_io_endpoint_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  DREQ;
  logic                  DACK;
  logic                  IOR_N;
  logic                  IOW_N;
  logic                  EOP_N;
  logic [DATA_WIDTH-1:0] DB_IN;
  logic [DATA_WIDTH-1:0] DB_OUT;
  logic                  DB_OE;

  // DMA controller side
  modport master (
    input  DREQ, DB_OUT, DB_OE,
    output DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );

  // Peripheral endpoint side
  modport slave (
    output DREQ, DB_OUT, DB_OE,
    input  DACK, IOR_N, IOW_N, EOP_N, DB_IN
  );
endinterface

// File: rtl/dma_io_endpoint.sv
// Single-channel 8237-style DMA peripheral endpoint with a local FIFO.
module dma_io_endpoint #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned THRESH     = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    EN,
  input  logic                    DIR,
  input  logic                    CLEAR,
  dma_io_endpoint_if.slave        bus,
  input  logic                    loc_in_valid,
  input  logic [DATA_WIDTH-1:0]   loc_in_data,
  output logic                    loc_in_ready,
  output logic                    loc_out_valid,
  output logic [DATA_WIDTH-1:0]   loc_out_data,
  input  logic                    loc_out_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    done,
  output logic                    underflow,
  output logic                    overflow
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic                  dreq_c, drive_c;
  logic                  stb_n, stb_n_q, dack_q;
  logic                  eop_seen_q, eop_seen_d;
  logic                  xfer_busy, completion, dma_ok;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  full, empty;
  logic                  loc_push, loc_pop, dma_push, dma_pop, push, pop;
  logic                  dma_under, dma_over;
  logic [DATA_WIDTH-1:0] push_data;
  logic [CNT_W-1:0]      count_d, free_cur, free_nxt;
  logic                  cond_cur, cond_nxt;

  // Active strobe selection and completion (rising edge while acknowledged)
  assign stb_n      = DIR ? bus.IOW_N : bus.IOR_N;
  assign xfer_busy  = bus.DACK && !stb_n;
  assign completion = dack_q && !stb_n_q && stb_n;
  assign dma_ok     = completion && (state_q != ST_DONE);
  assign eop_seen_d = xfer_busy ? (eop_seen_q || !bus.EOP_N) : 1'b0;

  // FIFO status and local handshakes
  assign full          = (fifo_count == CNT_W'(DEPTH));
  assign empty         = (fifo_count == '0);
  assign loc_in_ready  = !full && !DIR && (state_q != ST_DONE);
  assign loc_out_valid = !empty && DIR;
  assign loc_out_data  = mem[rd_ptr];

  // Source mode pairs local push with DMA pop; sink mode pairs DMA push with local pop
  assign loc_push  = loc_in_valid && loc_in_ready;
  assign loc_pop   = loc_out_valid && loc_out_ready;
  assign dma_pop   = dma_ok && !DIR && !empty;
  assign dma_push  = dma_ok && DIR && (!full || loc_pop);
  assign dma_under = dma_ok && !DIR && empty;
  assign dma_over  = dma_ok && DIR && full && !loc_pop;
  assign push      = loc_push || dma_push;
  assign pop       = loc_pop || dma_pop;
  assign push_data = DIR ? hold_q : loc_in_data;
  assign count_d   = CLEAR ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));

  // Request condition on current and post-update occupancy
  assign free_cur = CNT_W'(DEPTH) - fifo_count;
  assign free_nxt = CNT_W'(DEPTH) - count_d;
  assign cond_cur = DIR ? (free_cur >= CNT_W'(THRESH)) : (fifo_count >= CNT_W'(THRESH));
  assign cond_nxt = DIR ? (free_nxt >= CNT_W'(THRESH)) : (count_d >= CNT_W'(THRESH));

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; CLEAR returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (EN && cond_cur) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.DACK)             state_d = ST_XFER;
        else if (!EN || !cond_cur) state_d = ST_IDLE;
      end
      ST_XFER: begin
        if (completion && eop_seen_q) state_d = ST_DONE;
        else if (!bus.DACK)           state_d = (EN && cond_nxt) ? ST_REQ : ST_IDLE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (CLEAR) state_d = ST_IDLE;
  end

  // FSM outputs: DREQ holds through an in-flight strobe, then follows EN && cond
  always_comb begin
    dreq_c  = 1'b0;
    drive_c = 1'b0;
    case (state_q)
      ST_REQ:  dreq_c = 1'b1;
      ST_XFER: dreq_c = xfer_busy ? bus.DREQ : (EN && cond_nxt);
      default: dreq_c = 1'b0;
    endcase
    if (CLEAR || (state_d == ST_DONE)) dreq_c = 1'b0;
    drive_c = bus.DACK && !bus.IOR_N && !DIR && (state_q != ST_DONE);
  end

  // Strobe history, bus outputs, FIFO pointers and sticky flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stb_n_q    <= 1'b1;
      dack_q     <= 1'b0;
      eop_seen_q <= 1'b0;
      hold_q     <= '0;
      bus.DREQ   <= 1'b0;
      bus.DB_OE  <= 1'b0;
      bus.DB_OUT <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      done       <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      stb_n_q    <= stb_n;
      dack_q     <= bus.DACK;
      eop_seen_q <= eop_seen_d;
      if (bus.DACK && !bus.IOW_N && DIR) hold_q <= bus.DB_IN;
      bus.DREQ   <= dreq_c;
      bus.DB_OE  <= drive_c;
      bus.DB_OUT <= (drive_c && !empty) ? mem[rd_ptr] : '0;
      fifo_count <= count_d;
      if (CLEAR) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        done      <= 1'b0;
        underflow <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (state_d == ST_DONE) done      <= 1'b1;
        if (dma_under)          underflow <= 1'b1;
        if (dma_over)           overflow  <= 1'b1;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (push && !CLEAR) mem[wr_ptr] <= push_data;
  end
endmodule

// File: tb/tb_dma_io_endpoint.sv
// Directed bench for dma_io_endpoint (THRESH=1 and THRESH=4 instances share stimulus).
module tb_dma_io_endpoint;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       EN, DIR, CLEAR;
  logic       loc_in_valid, loc_out_ready;
  logic [7:0] loc_in_data;

  logic       loc_in_ready1, loc_out_valid1, done1, underflow1, overflow1;
  logic [7:0] loc_out_data1;
  logic [3:0] fifo_count1;
  logic       loc_in_ready4, loc_out_valid4, done4, underflow4, overflow4;
  logic [7:0] loc_out_data4;
  logic [3:0] fifo_count4;

  int total = 0;
  int bad   = 0;

  dma_io_endpoint_if #(.DATA_WIDTH(8)) bus1 ();
  dma_io_endpoint_if #(.DATA_WIDTH(8)) bus4 ();

  assign bus4.DACK  = bus1.DACK;
  assign bus4.IOR_N = bus1.IOR_N;
  assign bus4.IOW_N = bus1.IOW_N;
  assign bus4.EOP_N = bus1.EOP_N;
  assign bus4.DB_IN = bus1.DB_IN;

  dma_io_endpoint #(.DATA_WIDTH(8), .DEPTH(8), .THRESH(1)) u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIR(DIR), .CLEAR(CLEAR), .bus(bus1),
    .loc_in_valid(loc_in_valid), .loc_in_data(loc_in_data), .loc_in_ready(loc_in_ready1),
    .loc_out_valid(loc_out_valid1), .loc_out_data(loc_out_data1), .loc_out_ready(loc_out_ready),
    .fifo_count(fifo_count1), .done(done1), .underflow(underflow1), .overflow(overflow1)
  );

  dma_io_endpoint #(.DATA_WIDTH(8), .DEPTH(8), .THRESH(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIR(DIR), .CLEAR(CLEAR), .bus(bus4),
    .loc_in_valid(loc_in_valid), .loc_in_data(loc_in_data), .loc_in_ready(loc_in_ready4),
    .loc_out_valid(loc_out_valid4), .loc_out_data(loc_out_data4), .loc_out_ready(loc_out_ready),
    .fifo_count(fifo_count4), .done(done4), .underflow(underflow4), .overflow(overflow4)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EN = 1'b0; DIR = 1'b0; CLEAR = 1'b0;
    loc_in_valid = 1'b0; loc_in_data = 8'h00; loc_out_ready = 1'b0;
    bus1.DACK = 1'b0; bus1.IOR_N = 1'b1; bus1.IOW_N = 1'b1; bus1.EOP_N = 1'b1;
    bus1.DB_IN = 8'h00;
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    idle_inputs();
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  // One strobe: two low cycles then release; completion lands on the third edge
  task automatic pulse(input logic use_iow, input logic [7:0] d, input logic eop);
    bus1.DB_IN = d;
    if (use_iow) bus1.IOW_N = 1'b0;
    else         bus1.IOR_N = 1'b0;
    bus1.EOP_N = !eop;
    tick();
    tick();
    bus1.IOR_N = 1'b1;
    bus1.IOW_N = 1'b1;
    bus1.EOP_N = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] sink_bytes [4];
    logic [7:0] src_bytes [4];
    sink_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    src_bytes  = '{8'h10, 8'h20, 8'h30, 8'h40};

    // Reset state, observed asynchronously before any clock edge
    RESET = 1'b1;
    idle_inputs();
    #1;
    check("rst_dreq",  32'(bus1.DREQ), 32'd0);
    check("rst_oe",    32'(bus1.DB_OE), 32'd0);
    check("rst_dbout", 32'(bus1.DB_OUT), 32'd0);
    check("rst_count", 32'(fifo_count1), 32'd0);
    check("rst_flags", 32'({done1, underflow1, overflow1}), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // Source single transfer
    EN = 1'b1; DIR = 1'b0;
    loc_in_valid = 1'b1; loc_in_data = 8'hA5;
    tick();
    loc_in_valid = 1'b0;
    check("src_count1", 32'(fifo_count1), 32'd1);
    check("src_dreq_e1", 32'(bus1.DREQ), 32'd0);
    tick();
    check("src_dreq_e2", 32'(bus1.DREQ), 32'd0);
    tick();
    check("src_dreq_up", 32'(bus1.DREQ), 32'd1);
    bus1.DACK = 1'b1;
    tick();
    bus1.IOR_N = 1'b0;
    tick();
    tick();
    check("src_oe",     32'(bus1.DB_OE), 32'd1);
    check("src_dbout",  32'(bus1.DB_OUT), 32'hA5);
    bus1.IOR_N = 1'b1;
    tick();
    check("src_count0", 32'(fifo_count1), 32'd0);
    check("src_dreq_dn", 32'(bus1.DREQ), 32'd0);
    check("src_oe_off", 32'(bus1.DB_OE), 32'd0);
    bus1.DACK = 1'b0;
    tick();

    // Sink demand burst then local drain in order
    reset_dut();
    DIR = 1'b1; EN = 1'b1; bus1.DACK = 1'b1;
    for (int i = 0; i < 4; i++) pulse(1'b1, sink_bytes[i], 1'b0);
    check("sink_count4", 32'(fifo_count1), 32'd4);
    bus1.DACK = 1'b0;
    tick();
    loc_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("sink_valid", 32'(loc_out_valid1), 32'd1);
      check("sink_data",  32'(loc_out_data1), 32'(sink_bytes[i]));
      tick();
    end
    loc_out_ready = 1'b0;
    check("sink_drained", 32'(fifo_count1), 32'd0);
    check("sink_valid0",  32'(loc_out_valid1), 32'd0);

    // Threshold (THRESH=4 instance) and overflow
    reset_dut();
    DIR = 1'b1; EN = 1'b1; bus1.DACK = 1'b1;
    for (int i = 0; i < 5; i++) pulse(1'b1, 8'(8'h50 + i), 1'b0);
    bus1.DACK = 1'b0;
    tick();
    tick();
    check("thr_count5", 32'(fifo_count4), 32'd5);
    check("thr_dreq5",  32'(bus4.DREQ), 32'd0);
    loc_out_ready = 1'b1;
    tick();
    loc_out_ready = 1'b0;
    check("thr_count4", 32'(fifo_count4), 32'd4);
    check("thr_dreq_e1", 32'(bus4.DREQ), 32'd0);
    tick();
    check("thr_dreq_e2", 32'(bus4.DREQ), 32'd0);
    tick();
    check("thr_dreq_up", 32'(bus4.DREQ), 32'd1);
    bus1.DACK = 1'b1;
    for (int i = 0; i < 4; i++) pulse(1'b1, 8'(8'h55 + i), 1'b0);
    check("full_count8", 32'(fifo_count4), 32'd8);
    check("full_no_ovf", 32'(overflow4), 32'd0);
    pulse(1'b1, 8'hEE, 1'b0);
    check("ovf_flag",   32'(overflow4), 32'd1);
    check("ovf_count8", 32'(fifo_count4), 32'd8);
    check("ovf_head",   32'(loc_out_data4), 32'h51);
    bus1.DACK = 1'b0;
    tick();

    // Underflow on empty source, then CLEAR drops the flag
    reset_dut();
    DIR = 1'b0; EN = 1'b1; bus1.DACK = 1'b1;
    bus1.IOR_N = 1'b0;
    tick();
    tick();
    check("udf_oe",    32'(bus1.DB_OE), 32'd1);
    check("udf_dbout", 32'(bus1.DB_OUT), 32'h00);
    bus1.IOR_N = 1'b1;
    tick();
    check("udf_flag",  32'(underflow1), 32'd1);
    check("udf_count", 32'(fifo_count1), 32'd0);
    bus1.DACK = 1'b0;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    check("udf_clear", 32'(underflow1), 32'd0);

    // Terminal count on the third strobe, later strobes ignored, CLEAR recovers
    reset_dut();
    DIR = 1'b0; EN = 1'b1;
    loc_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      loc_in_data = src_bytes[i];
      tick();
    end
    loc_in_valid = 1'b0;
    check("tc_count4", 32'(fifo_count1), 32'd4);
    bus1.DACK = 1'b1;
    tick();
    tick();
    pulse(1'b0, 8'h00, 1'b0);
    pulse(1'b0, 8'h00, 1'b0);
    check("tc_done_early", 32'(done1), 32'd0);
    pulse(1'b0, 8'h00, 1'b1);
    check("tc_done",   32'(done1), 32'd1);
    check("tc_dreq",   32'(bus1.DREQ), 32'd0);
    check("tc_count1", 32'(fifo_count1), 32'd1);
    check("tc_ready",  32'(loc_in_ready1), 32'd0);
    bus1.IOR_N = 1'b0;
    tick();
    tick();
    check("tc_ign_oe", 32'(bus1.DB_OE), 32'd0);
    bus1.IOR_N = 1'b1;
    tick();
    check("tc_ign_count", 32'(fifo_count1), 32'd1);
    check("tc_ign_udf",   32'(underflow1), 32'd0);
    bus1.DACK = 1'b0;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    check("clr_count", 32'(fifo_count1), 32'd0);
    check("clr_done",  32'(done1), 32'd0);
    check("clr_ready", 32'(loc_in_ready1), 32'd1);
    tick();
    tick();
    check("clr_dreq",  32'(bus1.DREQ), 32'd0);

    // Asynchronous reset during an in-flight strobe
    reset_dut();
    DIR = 1'b0; EN = 1'b1;
    loc_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      loc_in_data = 8'(i + 1);
      tick();
    end
    loc_in_valid = 1'b0;
    bus1.DACK = 1'b1;
    tick();
    tick();
    bus1.IOR_N = 1'b0;
    tick();
    check("ar_pre_oe",    32'(bus1.DB_OE), 32'd1);
    check("ar_pre_dreq",  32'(bus1.DREQ), 32'd1);
    check("ar_pre_count", 32'(fifo_count1), 32'd3);
    #2;
    RESET = 1'b1;
    #1;
    check("ar_dreq",  32'(bus1.DREQ), 32'd0);
    check("ar_oe",    32'(bus1.DB_OE), 32'd0);
    check("ar_count", 32'(fifo_count1), 32'd0);
    bus1.IOR_N = 1'b1;
    bus1.DACK  = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    tick();
    check("ar_idle_dreq", 32'(bus1.DREQ), 32'd0);
    loc_in_valid = 1'b1; loc_in_data = 8'h77;
    tick();
    loc_in_valid = 1'b0;
    tick();
    tick();
    check("ar_rereq", 32'(bus1.DREQ), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_io_endpoint.md
Name: dma_io_endpoint

Overview:
Single-channel peripheral endpoint for the 8237-style DMA controller. It sits on the device side of the DREQ/DACK handshake and is the responder to the controller's IOR_N/IOW_N strobes. An internal FIFO lets local logic supply bytes for I/O-read (device-to-memory) transfers or receive bytes from I/O-write (memory-to-device) transfers. It raises DREQ from FIFO fill level, honours DACK and terminal count (EOP_N), and flags protocol errors.

Parameters:
DATA_WIDTH, 8, width of DB and FIFO entries
DEPTH, 8, FIFO entries; power of two, at least 2
THRESH, 1, DREQ raise level: source mode count>=THRESH, sink mode free>=THRESH; range 1..DEPTH

Ports:
CLK  in  1  clock, all logic on posedge
RESET  in  1  asynchronous, active-high reset
EN  in  1  channel enable; DREQ forced low when 0
DIR  in  1  0=source (controller issues IOR_N, endpoint drives DB); 1=sink (controller issues IOW_N, endpoint captures DB); change only while EN=0
CLEAR  in  1  sync pulse: flush FIFO, clear done/underflow/overflow, DONE->IDLE
DREQ  out  1  DMA request, active-high, registered
DACK  in  1  DMA acknowledge, active-high
IOR_N  in  1  I/O read strobe, active-low
IOW_N  in  1  I/O write strobe, active-low
EOP_N  in  1  terminal count / end of process, active-low
DB_IN  in  DATA_WIDTH  data bus input
DB_OUT  out  DATA_WIDTH  data bus output
DB_OE  out  1  DB_OUT enable
loc_in_valid  in  1  local push request (source mode)
loc_in_data  in  DATA_WIDTH  local push data
loc_in_ready  out  1  !full && DIR==0 && state!=DONE
loc_out_valid  out  1  !empty && DIR==1
loc_out_data  out  DATA_WIDTH  FIFO head, fall-through
loc_out_ready  in  1  local pop acknowledge
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
done  out  1  sticky; terminal count seen
underflow  out  1  sticky; source strobe with empty FIFO
overflow  out  1  sticky; sink strobe with full FIFO

Behaviour:
- Reset (async): state IDLE, DREQ=0, DB_OE=0, DB_OUT=0, fifo_count=0, done/underflow/overflow=0. Strobe-history registers reset to 1.
- Active strobe: STB_N = IOR_N when DIR=0, IOW_N when DIR=1. The other strobe is ignored. A strobe is honoured only while DACK=1.
- Strobe completion: rising edge of STB_N, i.e. registered previous STB_N=0 and current 1, with DACK=1 in the previous cycle. Exactly one transfer per completion.
- cond: source mode count>=THRESH; sink mode (DEPTH-count)>=THRESH.
- FSM:
  - IDLE: DREQ=0. Goes to REQ when EN && cond.
  - REQ: DREQ=1. Goes to XFER on DACK=1. Goes to IDLE if !EN or !cond while DACK=0.
  - XFER: DREQ = EN && cond, evaluated on the post-update count. On each completion, one transfer. If EOP_N was low in any cycle of the current strobe, go to DONE after the completion. When DACK falls with no EOP, go to REQ if EN && cond, else IDLE.
  - DONE: DREQ=0, done=1. Strobes are ignored. CLEAR goes to IDLE.
- Because DREQ is registered, it changes one cycle after the FSM/cond change.
- Source transfer:
  - DB_OE=1 and DB_OUT=FIFO head while DACK && !IOR_N && DIR==0; otherwise DB_OE=0.
  - Completion pops one entry.
  - If the FIFO is empty: DB_OUT=0, no pop, underflow=1.
- Sink transfer:
  - A hold register captures DB_IN every cycle that DACK && !IOW_N.
  - Completion pushes the hold register.
  - If the FIFO is full: data is dropped, overflow=1.
- Simultaneous local and DMA FIFO ops in the same cycle are both applied and count is unchanged. A push into a full FIFO with a same-cycle pop is allowed.
- FIFO pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- CLEAR has priority over all same-cycle FIFO ops. It empties the FIFO and leaves DREQ=0 next cycle.
- EN deasserted mid-XFER: the in-flight strobe still completes. DREQ drops after that completion.

Test Plan:
- Source single transfer: DIR=0, THRESH=1, push 0xA5 -> DREQ=1 two cycles later. DACK=1 then IOR_N low 2 cycles -> DB_OE=1, DB_OUT=0xA5. IOR_N rises -> count=0, DREQ=0 next cycle.
- Sink demand burst: DIR=1, DEPTH=8. DACK held, 4 IOW_N pulses with DB_IN=0x11,0x22,0x33,0x44 -> count=4; loc_out_data pops 0x11..0x44 in order.
- Threshold and full: sink THRESH=4, count=5 -> DREQ=0; pop to count=4 -> DREQ=1. Strobe with count=8 -> overflow=1, count stays 8.
- Underflow: source, empty FIFO, DACK+IOR_N pulse -> DB_OUT=0x00, underflow=1, count=0.
- Terminal count: EOP_N low during the 3rd strobe -> done=1, DREQ=0, later strobes ignored. CLEAR -> IDLE, count=0, flags cleared.
- Async reset mid-XFER (count=3): RESET high -> DREQ=0, DB_OE=0, count=0 immediately without a clock edge; FSM IDLE after release.
